// File: rtl/seg_display_mux.sv
// seg_display_mux: parametrised multiplexed seven-segment driver.
// Shows a WIDTH-bit number in hex, or in unsigned decimal through a sequential
// double-dabble converter. Supports decimal overflow indication, per-digit
// decimal points, leading-zero blanking and a global blank ("empty") input.
// All outputs are registered and active-low, so they can drive board pins directly.
module seg_display_mux #(
    parameter int DIGITS       = 4,
    parameter int WIDTH        = 16,
    parameter int REFRESH_BITS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  number,
    input  logic              mode,
    input  logic              blank_lz,
    input  logic [DIGITS-1:0] dp,
    input  logic              empty,
    output logic [6:0]        seg,
    output logic              dp_out,
    output logic [DIGITS-1:0] an,
    output logic              busy
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int PAD_W = (WIDTH > BCD_W) ? WIDTH : BCD_W;
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CONV    = 2'd1;
    localparam logic [1:0] ST_PUBLISH = 2'd2;

    logic [1:0]              state_q, state_d;
    logic [WIDTH-1:0]        shadow_q, shadow_d;
    logic                    mode_sh_q, mode_sh_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [BCD_W-1:0]        bcd_q, bcd_d;
    logic                    conv_ovf_q, conv_ovf_d;
    logic [BCD_W-1:0]        digits_q, digits_d;
    logic                    ovf_q, ovf_d;
    logic [REFRESH_BITS-1:0] prescaler_q, prescaler_d;
    logic [IDX_W-1:0]        index_q, index_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_out_q, dp_out_d;
    logic [DIGITS-1:0]       an_q, an_d;

    logic [BCD_W-1:0]        bcd_adj;
    logic [PAD_W-1:0]        padded;
    logic [3:0]              cur_digit;
    logic                    cur_dp;
    logic                    cur_blank;
    logic                    zero_run;

    // Active-low seven-segment pattern (gfedcba) for one hex digit
    function automatic logic [6:0] seg_code(input logic [3:0] v);
        logic [6:0] code;
        case (v)
            4'h0: code = 7'h40;
            4'h1: code = 7'h79;
            4'h2: code = 7'h24;
            4'h3: code = 7'h30;
            4'h4: code = 7'h19;
            4'h5: code = 7'h12;
            4'h6: code = 7'h02;
            4'h7: code = 7'h78;
            4'h8: code = 7'h00;
            4'h9: code = 7'h10;
            4'hA: code = 7'h08;
            4'hB: code = 7'h03;
            4'hC: code = 7'h46;
            4'hD: code = 7'h21;
            4'hE: code = 7'h06;
            default: code = 7'h0E;
        endcase
        return code;
    endfunction

    // Double-dabble correction: every BCD nibble of 5 or more gets +3 before the shift
    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end else begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4];
            end
        end
    end

    // Converter FSM: capture, optional WIDTH-step decimal conversion, then publish
    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        mode_sh_d  = mode_sh_q;
        cnt_d      = cnt_q;
        bcd_d      = bcd_q;
        conv_ovf_d = conv_ovf_q;
        digits_d   = digits_q;
        ovf_d      = ovf_q;
        padded     = '0;
        case (state_q)
            ST_IDLE: begin
                shadow_d   = number;
                mode_sh_d  = mode;
                cnt_d      = '0;
                bcd_d      = '0;
                conv_ovf_d = 1'b0;
                state_d    = mode ? ST_CONV : ST_PUBLISH;
            end
            ST_CONV: begin
                bcd_d    = {bcd_adj[BCD_W-2:0], shadow_q[WIDTH-1]};
                shadow_d = shadow_q << 1;
                if (bcd_adj[BCD_W-1]) begin
                    conv_ovf_d = 1'b1;
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = ST_PUBLISH;
                end
            end
            ST_PUBLISH: begin
                if (mode_sh_q) begin
                    digits_d = bcd_q;
                    ovf_d    = conv_ovf_q;
                end else begin
                    padded   = PAD_W'(shadow_q);
                    digits_d = padded[BCD_W-1:0];
                    ovf_d    = 1'b0;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Free-running prescaler; the scan index steps once per prescaler wrap
    always_comb begin
        prescaler_d = prescaler_q + REFRESH_BITS'(1);
        index_d     = index_q;
        if (&prescaler_q) begin
            if (index_q == IDX_W'(DIGITS - 1)) begin
                index_d = '0;
            end else begin
                index_d = index_q + IDX_W'(1);
            end
        end
    end

    // Pick the current digit and decide what the pins show this cycle
    always_comb begin
        cur_digit = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        zero_run  = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run & (digits_q[4*i +: 4] == 4'd0);
            if (index_q == IDX_W'(i)) begin
                cur_digit = digits_q[4*i +: 4];
                cur_dp    = dp[i];
                cur_blank = zero_run && (i != 0);
            end
        end
        an_d     = '1;
        seg_d    = 7'h7F;
        dp_out_d = 1'b1;
        if (!empty) begin
            for (int i = 0; i < DIGITS; i++) begin
                an_d[i] = (index_q != IDX_W'(i));
            end
            dp_out_d = ~cur_dp;
            if (ovf_q) begin
                seg_d = 7'h3F;
            end else if (blank_lz && cur_blank) begin
                seg_d = 7'h7F;
            end else begin
                seg_d = seg_code(cur_digit);
            end
        end
    end

    // State registers; reset drops any conversion in flight and blanks the display
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            shadow_q    <= '0;
            mode_sh_q   <= 1'b0;
            cnt_q       <= '0;
            bcd_q       <= '0;
            conv_ovf_q  <= 1'b0;
            digits_q    <= '0;
            ovf_q       <= 1'b0;
            prescaler_q <= '0;
            index_q     <= '0;
            seg_q       <= 7'h7F;
            dp_out_q    <= 1'b1;
            an_q        <= '1;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            mode_sh_q   <= mode_sh_d;
            cnt_q       <= cnt_d;
            bcd_q       <= bcd_d;
            conv_ovf_q  <= conv_ovf_d;
            digits_q    <= digits_d;
            ovf_q       <= ovf_d;
            prescaler_q <= prescaler_d;
            index_q     <= index_d;
            seg_q       <= seg_d;
            dp_out_q    <= dp_out_d;
            an_q        <= an_d;
        end
    end

    assign seg    = seg_q;
    assign dp_out = dp_out_q;
    assign an     = an_q;
    assign busy   = (state_q == ST_CONV);

endmodule

// File: tb/tb_seg_display_mux.sv
// Testbench for seg_display_mux with DIGITS=4, WIDTH=16, REFRESH_BITS=2.
// A timeline model predicts captures, publish points and scan position from
// edge counts, and derives digit values with plain division / shifts.
module tb_seg_display_mux;

    localparam int DIGITS = 4;
    localparam int WIDTH  = 16;
    localparam int RB     = 2;

    logic              clk;
    logic              rst;
    logic [WIDTH-1:0]  number;
    logic              mode;
    logic              blank_lz;
    logic [DIGITS-1:0] dp_in;
    logic              empty;
    logic [6:0]        seg;
    logic              dp_out;
    logic [DIGITS-1:0] an;
    logic              busy;

    int total = 0;
    int bad   = 0;

    seg_display_mux #(
        .DIGITS(DIGITS),
        .WIDTH(WIDTH),
        .REFRESH_BITS(RB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .number(number),
        .mode(mode),
        .blank_lz(blank_lz),
        .dp(dp_in),
        .empty(empty),
        .seg(seg),
        .dp_out(dp_out),
        .an(an),
        .busy(busy)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Model state: n counts rising edges since reset release
    int                n = 0;
    int                next_cap = 0;
    int                pub_at = -1;
    int                cap_edge = -1000;
    int                cap_val = 0;
    bit                cap_mode = 1'b0;
    int                pub_dig [DIGITS];
    bit                pub_ovf = 1'b0;
    int                m_idx;
    bit                m_lead;
    int                m_pow;
    logic [DIGITS-1:0] exp_an = '1;
    logic [6:0]        exp_seg = 7'h7F;
    logic              exp_dp = 1'b1;
    logic              exp_busy = 1'b0;

    // Reference model, evaluated on every rising edge or reset assertion
    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                n = 0;
                next_cap = 0;
                pub_at = -1;
                cap_edge = -1000;
                cap_mode = 1'b0;
                cap_val = 0;
                for (int i = 0; i < DIGITS; i++) pub_dig[i] = 0;
                pub_ovf = 1'b0;
                exp_an = '1;
                exp_seg = 7'h7F;
                exp_dp = 1'b1;
                exp_busy = 1'b0;
            end else begin
                m_idx = (n >> RB) % DIGITS;
                if (empty) begin
                    exp_an = '1;
                    exp_seg = 7'h7F;
                    exp_dp = 1'b1;
                end else begin
                    exp_an = '1;
                    exp_an[m_idx] = 1'b0;
                    m_lead = 1'b1;
                    for (int i = m_idx; i < DIGITS; i++) if (pub_dig[i] != 0) m_lead = 1'b0;
                    if (pub_ovf) exp_seg = 7'h3F;
                    else if (blank_lz && m_idx > 0 && m_lead) exp_seg = 7'h7F;
                    else exp_seg = seg_tab[pub_dig[m_idx]];
                    exp_dp = ~dp_in[m_idx];
                end
                if (n == next_cap) begin
                    cap_edge = n;
                    cap_val = int'(number);
                    cap_mode = mode;
                    pub_at = n + 1 + (mode ? WIDTH : 0);
                    next_cap = pub_at + 1;
                end else if (n == pub_at) begin
                    if (cap_mode) begin
                        m_pow = 1;
                        for (int i = 0; i < DIGITS; i++) begin
                            pub_dig[i] = (cap_val / m_pow) % 10;
                            m_pow = m_pow * 10;
                        end
                        pub_ovf = (cap_val >= m_pow);
                    end else begin
                        for (int i = 0; i < DIGITS; i++) pub_dig[i] = (cap_val >> (4 * i)) & 15;
                        pub_ovf = 1'b0;
                    end
                end
                exp_busy = cap_mode && (n >= cap_edge) && (n <= cap_edge + WIDTH - 1);
                n++;
            end
        end
    end

    // Every-cycle comparison of the DUT pins against the model
    initial begin
        forever begin
            @(negedge clk);
            total++;
            if (an !== exp_an || seg !== exp_seg || dp_out !== exp_dp || busy !== exp_busy) begin
                bad++;
                $display("[TB] FAIL model_cmp n=%0d got an=%b seg=%h dp=%b busy=%b want an=%b seg=%h dp=%b busy=%b",
                         n, an, seg, dp_out, busy, exp_an, exp_seg, exp_dp, exp_busy);
            end
        end
    end

    // Hand-computed literal check of all outputs
    task automatic checkOutput(input string name, input logic [DIGITS-1:0] e_an,
                               input logic [6:0] e_seg, input logic e_dp, input logic e_busy);
        total++;
        if (an !== e_an || seg !== e_seg || dp_out !== e_dp || busy !== e_busy) begin
            bad++;
            $display("[TB] FAIL %s: got an=%b seg=%h dp=%b busy=%b want an=%b seg=%h dp=%b busy=%b",
                     name, an, seg, dp_out, busy, e_an, e_seg, e_dp, e_busy);
        end
    endtask

    // Wait (bounded) until the falling edge that follows rising edge e
    task automatic waitForEdge(input int e);
        int guard = 0;
        while (n < e + 1 && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (n < e + 1) begin
            total++;
            bad++;
            $display("[TB] FAIL wait_edge_%0d: got n=%0d want n=%0d", e, n, e + 1);
        end
    endtask

    // Change inputs shortly after a falling edge
    task automatic applyStimulus(input logic [WIDTH-1:0] num, input logic md, input logic blz,
                                 input logic [DIGITS-1:0] dpv, input logic emp);
        #2;
        number = num;
        mode = md;
        blank_lz = blz;
        dp_in = dpv;
        empty = emp;
    endtask

    // Pulse reset for one cycle with new inputs in place
    task automatic startScenario(input logic [WIDTH-1:0] num, input logic md, input logic blz,
                                 input logic [DIGITS-1:0] dpv);
        #2;
        rst = 1'b0;
        number = num;
        mode = md;
        blank_lz = blz;
        dp_in = dpv;
        empty = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        number = 16'h1234;
        mode = 1'b0;
        blank_lz = 1'b0;
        dp_in = '0;
        empty = 1'b0;

        // Reset state, then hex BEEF
        repeat (2) @(negedge clk);
        checkOutput("reset_hold", 4'b1111, 7'h7F, 1'b1, 1'b0);
        number = 16'hBEEF;
        #2 rst = 1'b1;
        waitForEdge(0);  checkOutput("hex_first_an", 4'b1110, 7'h40, 1'b1, 1'b0);
        waitForEdge(3);  checkOutput("hex_d0_F", 4'b1110, 7'h0E, 1'b1, 1'b0);
        waitForEdge(7);  checkOutput("hex_d1_E", 4'b1101, 7'h06, 1'b1, 1'b0);
        waitForEdge(11); checkOutput("hex_d2_E", 4'b1011, 7'h06, 1'b1, 1'b0);
        waitForEdge(15); checkOutput("hex_d3_b", 4'b0111, 7'h03, 1'b1, 1'b0);
        waitForEdge(19); checkOutput("hex_wrap", 4'b1110, 7'h0E, 1'b1, 1'b0);

        // Decimal 1234: busy for 16 cycles, shown from cycle 18
        startScenario(16'd1234, 1'b1, 1'b0, 4'b0000);
        waitForEdge(0);  checkOutput("dec_busy_start", 4'b1110, 7'h40, 1'b1, 1'b1);
        waitForEdge(15); checkOutput("dec_busy_last", 4'b0111, 7'h40, 1'b1, 1'b1);
        waitForEdge(16); checkOutput("dec_busy_done", 4'b1110, 7'h40, 1'b1, 1'b0);
        waitForEdge(17); checkOutput("dec_not_yet", 4'b1110, 7'h40, 1'b1, 1'b0);
        waitForEdge(18); checkOutput("dec_d0_4", 4'b1110, 7'h19, 1'b1, 1'b1);
        waitForEdge(23); checkOutput("dec_d1_3", 4'b1101, 7'h30, 1'b1, 1'b1);
        waitForEdge(27); checkOutput("dec_d2_2", 4'b1011, 7'h24, 1'b1, 1'b1);
        waitForEdge(31); checkOutput("dec_d3_1", 4'b0111, 7'h79, 1'b1, 1'b1);

        // Overflow with 12345, then recovery with 9999
        startScenario(16'd12345, 1'b1, 1'b0, 4'b0000);
        waitForEdge(18); checkOutput("ovf_d0", 4'b1110, 7'h3F, 1'b1, 1'b1);
        waitForEdge(23); checkOutput("ovf_d1", 4'b1101, 7'h3F, 1'b1, 1'b1);
        waitForEdge(27); checkOutput("ovf_d2", 4'b1011, 7'h3F, 1'b1, 1'b1);
        waitForEdge(31); checkOutput("ovf_d3", 4'b0111, 7'h3F, 1'b1, 1'b1);
        applyStimulus(16'd9999, 1'b1, 1'b0, 4'b0000, 1'b0);
        waitForEdge(55); checkOutput("n9999_d1", 4'b1101, 7'h10, 1'b1, 1'b1);
        waitForEdge(59); checkOutput("n9999_d2", 4'b1011, 7'h10, 1'b1, 1'b1);
        waitForEdge(63); checkOutput("n9999_d3", 4'b0111, 7'h10, 1'b1, 1'b1);
        waitForEdge(67); checkOutput("n9999_d0", 4'b1110, 7'h10, 1'b1, 1'b1);

        // Leading-zero blanking and decimal point on digit 1
        startScenario(16'd7, 1'b1, 1'b1, 4'b0010);
        waitForEdge(19); checkOutput("blz_d0_7", 4'b1110, 7'h78, 1'b1, 1'b1);
        waitForEdge(23); checkOutput("blz_d1_dp", 4'b1101, 7'h7F, 1'b0, 1'b1);
        waitForEdge(27); checkOutput("blz_d2", 4'b1011, 7'h7F, 1'b1, 1'b1);
        waitForEdge(31); checkOutput("blz_d3", 4'b0111, 7'h7F, 1'b1, 1'b1);
        applyStimulus(16'd0, 1'b1, 1'b1, 4'b0010, 1'b0);
        waitForEdge(63); checkOutput("zero_d3", 4'b0111, 7'h7F, 1'b1, 1'b1);
        waitForEdge(67); checkOutput("zero_d0", 4'b1110, 7'h40, 1'b1, 1'b1);

        // Global blank, then release
        applyStimulus(16'd0, 1'b1, 1'b1, 4'b0010, 1'b1);
        waitForEdge(68); checkOutput("empty_on", 4'b1111, 7'h7F, 1'b1, 1'b1);
        applyStimulus(16'd0, 1'b1, 1'b1, 4'b0010, 1'b0);
        waitForEdge(69); checkOutput("empty_off", 4'b1101, 7'h7F, 1'b0, 1'b1);

        // Reset in the middle of a conversion, then a clean conversion of 4321
        startScenario(16'd1234, 1'b1, 1'b0, 4'b0000);
        waitForEdge(5);  checkOutput("mid_conv", 4'b1101, 7'h40, 1'b1, 1'b1);
        #2;
        rst = 1'b0;
        number = 16'd4321;
        #1;
        total++;
        if (busy !== 1'b0 || an !== 4'b1111) begin
            bad++;
            $display("[TB] FAIL mid_reset: got busy=%b an=%b want busy=0 an=1111", busy, an);
        end
        @(negedge clk);
        #2 rst = 1'b1;
        waitForEdge(15); checkOutput("rerun_busy", 4'b0111, 7'h40, 1'b1, 1'b1);
        waitForEdge(16); checkOutput("rerun_done", 4'b1110, 7'h40, 1'b1, 1'b0);
        waitForEdge(18); checkOutput("rerun_d0_1", 4'b1110, 7'h79, 1'b1, 1'b1);
        waitForEdge(23); checkOutput("rerun_d1_2", 4'b1101, 7'h24, 1'b1, 1'b1);
        waitForEdge(27); checkOutput("rerun_d2_3", 4'b1011, 7'h30, 1'b1, 1'b1);
        waitForEdge(31); checkOutput("rerun_d3_4", 4'b0111, 7'h19, 1'b1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
